// File: rtl/matvec_pkg.sv
// Shared types and arithmetic helpers for the matrix-vector engine.
// The state enum, width helpers and the output conversion live here.
package matvec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } state_t;

  function automatic int wbits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sum of K full-width products never overflows this width.
  function automatic int acc_w(
    input int dw,
    input int cw,
    input int k
  );
    return dw + cw + $clog2(k);
  endfunction

  // Caller keeps the low ow bits; with sat clear that is a plain wrap.
  function automatic logic signed [63:0] sat_conv(
    input logic signed [63:0] acc,
    input int                 ow,
    input bit                 sat
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (sat && (acc > hi)) return hi;
    if (sat && (acc < lo)) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/matvec_mac.sv
// Signed multiply-accumulate with clear on row end.
// Emits the converted row result on the last column.
module matvec_mac
  import matvec_pkg::*;
#(
  parameter int DW  = 8,
  parameter int CW  = 8,
  parameter int K   = 4,
  parameter int OW  = 9,
  parameter bit SAT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_last,
  input  logic signed [DW-1:0] i_x,
  input  logic signed [CW-1:0] i_a,
  output logic                 o_we,
  output logic signed [OW-1:0] o_res
);

  localparam int AW = acc_w(DW, CW, K);
  localparam int PW = DW + CW;

  logic signed [AW-1:0] r_acc;
  logic signed [PW-1:0] w_prod;
  logic signed [AW-1:0] w_sum;

  assign w_prod = PW'(i_x) * PW'(i_a);
  assign w_sum  = r_acc + AW'(w_prod);
  assign o_we   = i_en & i_last;
  assign o_res  = OW'(sat_conv(64'(w_sum), OW, SAT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= i_last ? '0 : w_sum;
    end
  end

endmodule

// File: rtl/matvec_engine.sv
// Y = A*X engine: loads X, runs one MAC per cycle, streams M results.
// Coefficient bank is written only while idle and persists across jobs.
module matvec_engine
  import matvec_pkg::*;
#(
  parameter int DW  = 8,
  parameter int CW  = 8,
  parameter int K   = 4,
  parameter int M   = 4,
  parameter int OW  = 9,
  parameter bit SAT = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cs_n,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [DW-1:0]             in_data,
  output logic                      in_ready,
  input  logic                      coef_we,
  input  logic [$clog2(M*K)-1:0]    coef_addr,
  input  logic [CW-1:0]             coef_data,
  output logic                      out_valid,
  output logic [OW-1:0]             out_data,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      finish
);

  localparam int AAW = $clog2(M * K);
  localparam int KW  = wbits(K);
  localparam int MW  = wbits(M);
  localparam logic [AAW:0] NCOEF = (AAW + 1)'(M * K);

  state_t r_state;
  state_t w_next;

  logic [KW-1:0]        r_k;
  logic [MW-1:0]        r_m;
  logic [MW-1:0]        r_o;
  logic                 r_finish;
  logic signed [DW-1:0] r_x    [K];
  logic signed [CW-1:0] r_coef [M*K];
  logic signed [OW-1:0] r_res  [M];

  logic           w_accept;
  logic           w_hs;
  logic           w_calc;
  logic           w_klast;
  logic           w_mlast;
  logic           w_olast;
  logic           w_cwr;
  logic [AAW-1:0] w_cidx;
  logic           w_res_we;
  logic [OW-1:0]  w_res;

  assign in_ready  = (r_state == LOAD) & ~cs_n;
  assign out_valid = (r_state == OUT) & ~cs_n;
  assign out_data  = r_res[r_o];
  assign busy      = (r_state != IDLE);
  assign finish    = r_finish;

  assign w_accept = in_ready & in_valid;
  assign w_hs     = out_valid & out_ready;
  assign w_calc   = (r_state == CALC);
  assign w_klast  = (r_k == KW'(K - 1));
  assign w_mlast  = (r_m == MW'(M - 1));
  assign w_olast  = (r_o == MW'(M - 1));
  assign w_cidx   = AAW'(r_m) * AAW'(K) + AAW'(r_k);
  assign w_cwr    = (r_state == IDLE) & ~cs_n & coef_we
                  & ({1'b0, coef_addr} < NCOEF);

  matvec_mac #(
    .DW (DW),
    .CW (CW),
    .K  (K),
    .OW (OW),
    .SAT(SAT)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_calc),
    .i_last(w_klast),
    .i_x   (r_x[r_k]),
    .i_a   (r_coef[w_cidx]),
    .o_we  (w_res_we),
    .o_res (w_res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start && !cs_n) w_next = LOAD;
      LOAD: if (w_accept && w_klast) w_next = CALC;
      CALC: if (w_klast && w_mlast) w_next = OUT;
      OUT:  if (w_hs && w_olast) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k      <= '0;
      r_m      <= '0;
      r_o      <= '0;
      r_finish <= 1'b0;
      for (int i = 0; i < K; i++) r_x[i] <= '0;
      for (int i = 0; i < M*K; i++) r_coef[i] <= '0;
      for (int i = 0; i < M; i++) r_res[i] <= '0;
    end else begin
      r_finish <= w_hs & w_olast;
      if (w_cwr) begin
        r_coef[coef_addr] <= coef_data;
      end
      if (w_accept) begin
        r_x[r_k] <= in_data;
        r_k      <= w_klast ? '0 : r_k + KW'(1);
      end
      // Column index wraps each row; row index advances on the last column.
      if (w_calc) begin
        r_k <= w_klast ? '0 : r_k + KW'(1);
        if (w_klast) begin
          r_m <= w_mlast ? '0 : r_m + MW'(1);
        end
      end
      if (w_res_we) begin
        r_res[r_m] <= w_res;
      end
      if (w_hs) begin
        r_o <= w_olast ? '0 : r_o + MW'(1);
      end
    end
  end

endmodule

// File: tb/tb_matvec_engine.sv
// Self-checking bench: saturating and wrapping engines side by side.
// Expected results come from a plain integer dot-product model.
module tb_matvec_engine;

  localparam int K = 4;
  localparam int M = 2;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       cs_n      = 1'b1;
  logic       start     = 1'b0;
  logic       in_valid  = 1'b0;
  logic [7:0] in_data   = '0;
  logic       coef_we   = 1'b0;
  logic [2:0] coef_addr = '0;
  logic [7:0] coef_data = '0;
  logic       out_ready = 1'b0;

  logic       in_ready_s, out_valid_s, busy_s, finish_s;
  logic [8:0] out_data_s;
  logic       in_ready_w, out_valid_w, busy_w, finish_w;
  logic [8:0] out_data_w;

  int n_chk  = 0;
  int n_fail = 0;

  int A [M][K];
  int X [K];
  int gs [M];
  int gw [M];
  int fin;
  bit tmo;

  always #5 clk = ~clk;

  matvec_engine #(
    .DW(8), .CW(8), .K(K), .M(M), .OW(9), .SAT(1'b1)
  ) u_sat (
    .clk(clk), .rst(rst), .cs_n(cs_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid_s), .out_data(out_data_s),
    .out_ready(out_ready), .busy(busy_s), .finish(finish_s)
  );

  matvec_engine #(
    .DW(8), .CW(8), .K(K), .M(M), .OW(9), .SAT(1'b0)
  ) u_wrap (
    .clk(clk), .rst(rst), .cs_n(cs_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_w),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid_w), .out_data(out_data_w),
    .out_ready(out_ready), .busy(busy_w), .finish(finish_w)
  );

  function automatic int ref_y(input int m);
    int s;
    s = 0;
    for (int k = 0; k < K; k++) s += A[m][k] * X[k];
    return s;
  endfunction

  function automatic int clamp9(input int v);
    if (v > 255) return 255;
    if (v < -256) return -256;
    return v;
  endfunction

  function automatic int wrap9(input int v);
    int r;
    r = v & 511;
    if (r >= 256) r -= 512;
    return r;
  endfunction

  function automatic int srand8();
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_coef(input int m, input int k, input int v);
    A[m][k]   = v;
    coef_we   = 1'b1;
    coef_addr = 3'(m * K + k);
    coef_data = 8'(v);
    step();
    coef_we   = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input int from, input int upto, input int vpct);
    int i;
    int cyc;
    i   = from;
    cyc = 0;
    while (i < upto && cyc < 300) begin
      in_valid = ($urandom_range(99) < vpct);
      in_data  = 8'(X[i]);
      @(negedge clk);
      if (in_valid && in_ready_s) i++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    if (i < upto) tmo = 1'b1;
  endtask

  task automatic drain(input int rpct);
    int n;
    int cyc;
    n   = 0;
    cyc = 0;
    fin = 0;
    while (n < M && cyc < 300) begin
      out_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (finish_s) fin++;
      if (out_valid_s && out_ready) begin
        gs[n] = int'($signed(out_data_s));
        gw[n] = int'($signed(out_data_w));
        n++;
      end
      step();
      cyc++;
    end
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (finish_s) fin++;
      step();
    end
    if (n < M) tmo = 1'b1;
  endtask

  task automatic wait_ovalid();
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!out_valid_s && cyc < 100) begin
      step();
      cyc++;
      @(negedge clk);
    end
    if (!out_valid_s) tmo = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step();
    @(negedge clk);
    n_chk++;
    if ({busy_s, in_ready_s, out_valid_s, finish_s} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctl sat got=%b exp=0000",
               {busy_s, in_ready_s, out_valid_s, finish_s});
    end
    n_chk++;
    if ({busy_w, in_ready_w, out_valid_w, finish_w} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctl wrap got=%b exp=0000",
               {busy_w, in_ready_w, out_valid_w, finish_w});
    end
    n_chk++;
    if (out_data_s !== 9'd0 || out_data_w !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_data got=%0h/%0h exp=0", out_data_s, out_data_w);
    end
    step();
    rst  = 1'b1;
    cs_n = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_load();
    tmo = 1'b0;
    for (int m = 0; m < M; m++)
      for (int k = 0; k < K; k++) set_coef(m, k, k + 1);
    for (int k = 0; k < K; k++) X[k] = srand8();
    go();
    feed(0, 2, 100);
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if ({busy_s, in_ready_s, out_valid_s, finish_s} !== 4'b0) begin
      n_fail++;
      $display("FAIL midload_rst got=%b exp=0000",
               {busy_s, in_ready_s, out_valid_s, finish_s});
    end
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    for (int m = 0; m < M; m++)
      for (int k = 0; k < K; k++) A[m][k] = 0;
    for (int k = 0; k < K; k++) X[k] = srand8();
    go();
    feed(0, K, 100);
    drain(100);
    n_chk++;
    if (tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_tmo got=%0d exp=0", tmo);
    end
    for (int m = 0; m < M; m++) begin
      n_chk++;
      if (gs[m] !== 0 || gw[m] !== 0) begin
        n_fail++;
        $display("FAIL cleared_coef y%0d got=%0d/%0d exp=0", m, gs[m], gw[m]);
      end
    end
    n_chk++;
    if (fin !== 1) begin
      n_fail++;
      $display("FAIL midload_finish got=%0d exp=1", fin);
    end
  endtask

  task automatic setup_basic();
    for (int k = 0; k < K; k++) set_coef(0, k, k + 1);
    for (int k = 0; k < K; k++) set_coef(1, k, -1);
    X = '{10, 20, 30, 40};
  endtask

  task automatic test_basic();
    tmo = 1'b0;
    setup_basic();
    go();
    feed(0, K, 100);
    drain(100);
    n_chk++;
    if (tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_tmo got=%0d exp=0", tmo);
    end
    n_chk++;
    if (gs[0] !== 255 || gs[1] !== -100) begin
      n_fail++;
      $display("FAIL basic_sat got=%0d,%0d exp=255,-100", gs[0], gs[1]);
    end
    n_chk++;
    if (gw[0] !== -212 || gw[1] !== -100) begin
      n_fail++;
      $display("FAIL basic_wrap got=%0d,%0d exp=-212,-100", gw[0], gw[1]);
    end
    n_chk++;
    if (fin !== 1 || busy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_finish got=%0d busy=%b exp=1 busy=0", fin, busy_s);
    end
  endtask

  task automatic test_backpressure();
    tmo = 1'b0;
    setup_basic();
    go();
    feed(0, K, 100);
    wait_ovalid();
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++;
      if (out_valid_s !== 1'b1 || int'($signed(out_data_s)) !== 255) begin
        n_fail++;
        $display("FAIL bp_hold c%0d got=%b/%0d exp=1/255", c, out_valid_s,
                 int'($signed(out_data_s)));
      end
      step();
    end
    out_ready = 1'b1;
    step();
    @(negedge clk);
    n_chk++;
    if (out_valid_s !== 1'b1 || int'($signed(out_data_s)) !== -100) begin
      n_fail++;
      $display("FAIL bp_next got=%b/%0d exp=1/-100", out_valid_s,
               int'($signed(out_data_s)));
    end
    step();
    out_ready = 1'b0;
    @(negedge clk);
    n_chk++;
    if (finish_s !== 1'b1 || tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_finish got=%b tmo=%0d exp=1", finish_s, tmo);
    end
    step();
  endtask

  task automatic test_gaps();
    int pat [7];
    int acc;
    int last;
    int d;
    pat  = '{1, 0, 0, 1, 1, 0, 1};
    tmo  = 1'b0;
    acc  = 0;
    last = -1;
    for (int m = 0; m < M; m++)
      for (int k = 0; k < K; k++) set_coef(m, k, srand8());
    for (int k = 0; k < K; k++) X[k] = srand8();
    go();
    for (int c = 0; c < 7; c++) begin
      in_valid = pat[c][0];
      in_data  = 8'(X[acc < K ? acc : 0]);
      @(negedge clk);
      if (in_valid && in_ready_s) begin
        acc++;
        if (acc == K) last = c;
      end
      step();
    end
    in_valid = 1'b0;
    n_chk++;
    if (acc !== 4 || last !== 6) begin
      n_fail++;
      $display("FAIL gap_accepts got=%0d@%0d exp=4@6", acc, last);
    end
    n_chk++;
    if (busy_s !== 1'b1 || in_ready_s !== 1'b0 || out_valid_s !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_calc got=%b%b%b exp=100", busy_s, in_ready_s,
               out_valid_s);
    end
    d = 1;
    @(negedge clk);
    while (!out_valid_s && d < 50) begin
      step();
      d++;
      @(negedge clk);
    end
    n_chk++;
    if (d !== M * K + 1) begin
      n_fail++;
      $display("FAIL gap_latency got=%0d exp=%0d", d, M * K + 1);
    end
    step();
    drain(100);
    for (int m = 0; m < M; m++) begin
      n_chk++;
      if (gs[m] !== clamp9(ref_y(m)) || gw[m] !== wrap9(ref_y(m))) begin
        n_fail++;
        $display("FAIL gap_y%0d got=%0d/%0d exp=%0d/%0d", m, gs[m], gw[m],
                 clamp9(ref_y(m)), wrap9(ref_y(m)));
      end
    end
  endtask

  task automatic test_ignored();
    tmo = 1'b0;
    for (int m = 0; m < M; m++)
      for (int k = 0; k < K; k++) set_coef(m, k, srand8());
    if (A[0][0] == 7) set_coef(0, 0, -7);
    for (int k = 0; k < K; k++) X[k] = srand8();
    go();
    feed(0, K, 100);
    start     = 1'b1;
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 8'd7;
    repeat (3) step();
    start   = 1'b0;
    coef_we = 1'b0;
    drain(100);
    for (int m = 0; m < M; m++) begin
      n_chk++;
      if (gs[m] !== clamp9(ref_y(m)) || gw[m] !== wrap9(ref_y(m))) begin
        n_fail++;
        $display("FAIL calc_ign_y%0d got=%0d/%0d exp=%0d/%0d", m, gs[m],
                 gw[m], clamp9(ref_y(m)), wrap9(ref_y(m)));
      end
    end
    go();
    feed(0, 1, 100);
    cs_n     = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if (in_ready_s !== 1'b0) begin
        n_fail++;
        $display("FAIL csn_ready c%0d got=%b exp=0", c, in_ready_s);
      end
      step();
    end
    in_valid = 1'b0;
    cs_n     = 1'b0;
    feed(1, K, 100);
    wait_ovalid();
    step();
    cs_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (out_valid_s !== 1'b0) begin
      n_fail++;
      $display("FAIL csn_ovalid got=%b exp=0", out_valid_s);
    end
    step();
    cs_n = 1'b0;
    drain(100);
    n_chk++;
    if (tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_tmo got=%0d exp=0", tmo);
    end
    for (int m = 0; m < M; m++) begin
      n_chk++;
      if (gs[m] !== clamp9(ref_y(m)) || gw[m] !== wrap9(ref_y(m))) begin
        n_fail++;
        $display("FAIL csn_y%0d got=%0d/%0d exp=%0d/%0d", m, gs[m], gw[m],
                 clamp9(ref_y(m)), wrap9(ref_y(m)));
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      tmo = 1'b0;
      for (int m = 0; m < M; m++)
        for (int k = 0; k < K; k++)
          set_coef(m, k, (j < 2) ? -128 : srand8());
      for (int k = 0; k < K; k++)
        X[k] = (j == 0) ? 127 : (j == 1) ? -128 : srand8();
      go();
      feed(0, K, int'($urandom_range(100, 40)));
      drain(int'($urandom_range(100, 40)));
      n_chk++;
      if (tmo !== 1'b0 || fin !== 1) begin
        n_fail++;
        $display("FAIL rand%0d_ctl tmo=%0d fin=%0d exp=0/1", j, tmo, fin);
      end
      for (int m = 0; m < M; m++) begin
        n_chk++;
        if (gs[m] !== clamp9(ref_y(m)) || gw[m] !== wrap9(ref_y(m))) begin
          n_fail++;
          $display("FAIL rand%0d_y%0d got=%0d/%0d exp=%0d/%0d", j, m,
                   gs[m], gw[m], clamp9(ref_y(m)), wrap9(ref_y(m)));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_basic();
    test_backpressure();
    test_gaps();
    test_ignored();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/matvec_engine.md
Name: matvec_engine

Overview:
- Parametrised successor of the fixed-size controller/logic pair. It loads an input vector X, then computes Y = A·X against a locally stored coefficient matrix A (M rows × K columns) with one signed MAC per cycle.
- Streams M results out through a valid/ready handshake.
- Adds configurable dimensions, an output-saturation mode, a ready-side backpressure handshake and a chip-select gate.

Parameters:
- DW, 8, X element width (signed)
- CW, 8, coefficient width (signed)
- K, 4, vector length (columns), ≥2
- M, 4, output count (rows), ≥1
- OW, 9, output width (signed)
- SAT, 1, 1 = clamp result to OW signed range; 0 = keep low OW bits (wrap)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- cs_n  in  1  chip select, active-low; when high, start/in_valid/coef_we are ignored and out_valid is forced low
- start  in  1  begin a job (sampled in IDLE only)
- in_valid  in  1  X word valid
- in_data  in  DW  X word
- in_ready  out  1  X word accepted when in_valid&in_ready
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(M*K)  row-major address, m*K+k
- coef_data  in  CW  coefficient value
- out_valid  out  1  result valid
- out_data  out  OW  result y[m], in order m=0..M-1
- out_ready  in  1  consumer accepts when out_valid&out_ready
- busy  out  1  high in any state except IDLE
- finish  out  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset (rst=0, asynchronous):
  - State=IDLE; counters, accumulator and X/result buffers cleared.
  - Coefficient bank cleared to 0.
  - All outputs 0.
- Arithmetic:
  - Products are DW+CW bits, signed.
  - Accumulator width AW = DW+CW+clog2(K); it cannot overflow.
  - Final conversion to OW: SAT=1 clamps to [-2^(OW-1), 2^(OW-1)-1]; SAT=0 truncates to the low OW bits.
- Coefficient writes:
  - Accepted only in IDLE with cs_n=0.
  - Writes are ignored while busy.
  - Addresses ≥ M*K are ignored.
  - Coefficients persist across jobs.
- FSM: IDLE → LOAD → CALC → OUT → IDLE.
  - IDLE: start & !cs_n → LOAD on the next edge. If coef_we and start occur in the same cycle, the write lands and the job starts with the new value.
  - LOAD:
    - in_ready=1 while cs_n=0.
    - Each accepted word is stored at x[kcnt] and kcnt increments.
    - After the K-th accept → CALC.
    - in_valid with cs_n=1 is not accepted.
    - There is no timeout; the block stays in LOAD indefinitely.
  - CALC:
    - Exactly M*K cycles. Cycle t computes acc += A[m][k]*x[k], with k = t mod K and m = t div K.
    - When k = K-1, the converted result is written to res[m] and acc is cleared.
    - Not gated by cs_n.
  - OUT:
    - out_valid=1 (when cs_n=0) and out_data=res[ocnt].
    - ocnt advances on each handshake.
    - out_data is held stable while out_valid & !out_ready.
    - After the M-th handshake → IDLE, and finish pulses in the first IDLE cycle.
- Latency: first out_valid occurs M*K+1 cycles after the K-th input accept.
- start outside IDLE is ignored (no queueing).
- Reset mid-job aborts immediately. No partial result or finish is produced.
- in_ready and out_valid are never high in the same cycle.

Decomposition:
- Package matvec_pkg holds:
  - the state enum (IDLE, LOAD, CALC, OUT)
  - a clog2-based width helper and the AW formula
  - a function sat_conv(acc, SAT) returning OW bits
- Natural sub-module: matvec_mac, a signed multiply-accumulate with clear-on-row-end and the sat_conv output stage.
- FSM, counters and buffers stay in matvec_engine.

Test Plan:
1. Reset mid-LOAD (after 2 of 4 words), then a fresh job → busy=0, out_valid=0, finish=0, and coefficients read back as 0 on the next job (all outputs 0).
2. Basic job, K=4, M=2, SAT=1:
   - Stimulus: A row0=[1,2,3,4], row1=[-1,-1,-1,-1]; X=[10,20,30,40].
   - Response: out_data sequence 255 (300 clamped), then -100; finish pulses once.
3. Same stimulus with SAT=0 → 300 wraps to -212, then -100.
4. Backpressure:
   - out_ready low for 5 cycles with out_valid high → out_data holds 255 unchanged.
   - Then out_ready=1 → second result appears in the next cycle.
5. in_valid gaps:
   - Pattern 1,0,0,1,1,0,1 → exactly 4 accepts.
   - CALC starts the cycle after the 4th accept; first out_valid follows 9 cycles later (M*K+1).
6. Ignored-input cases:
   - start and coef_we (addr 0, data 7) during CALC → no effect; results unchanged.
   - cs_n=1 during LOAD → in_ready=0 and no words consumed.
